m_memarb: RTL and testbench
===========================

M_MEMARB -- requirements
Module: m_memarb

Interface
REQ-001 Parameter CNT_W, default 16, width of each per-port grant counter.
REQ-002 w_clk  in  1  single clock; all state updates on posedge.
REQ-003 w_rst  in  1  asynchronous, active-high reset.
REQ-004 w_req0  in  1  port-0 request; held high until r_ack0 is seen.
REQ-005 w_we0  in  1  port-0 write enable; 0 = read.
REQ-006 w_addr0  in  32  port-0 byte address.
REQ-007 w_wdata0  in  32  port-0 write data.
REQ-008 w_req1, w_we1, w_addr1, w_wdata1  in  1/1/32/32  port-1 equivalents.
REQ-009 r_ack0, r_ack1  out  1  one-cycle completion pulse per port.
REQ-010 r_err  out  1  error flag, valid only while an ack is high.
REQ-011 r_rdata  out  32  read data, valid only while an ack is high.
REQ-012 w_mem_addr  out  11  word address to the single-port 2048x32 memory.
REQ-013 w_mem_we  out  1  memory write enable.
REQ-014 w_mem_din  out  32  memory write data.
REQ-015 w_mem_dout  in  32  memory combinational read data.
REQ-016 r_cnt0, r_cnt1  out  CNT_W  saturating count of completed accesses per port.
REQ-017 r_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS, DONE, encoded in a 2-bit register.
REQ-019 IDLE: if any w_reqN is high, the FSM SHALL latch the winner index, go to ACCESS, and stay in IDLE otherwise.
REQ-020 With both requests high, the winner SHALL be the port not in r_last (round-robin); r_last SHALL update to the winner on the IDLE->ACCESS transition.
REQ-021 A single request SHALL win regardless of r_last.
REQ-022 ACCESS lasts exactly one cycle: w_mem_addr = winner addr[12:2], w_mem_din = winner wdata, w_mem_we = winner we AND NOT error.
REQ-023 Error SHALL be addr[1:0] != 0 OR addr[31:13] != 0; on error no write occurs and r_rdata SHALL be 0.
REQ-024 At the posedge ending ACCESS: r_rdata <= (read AND no error) ? w_mem_dout : 0; r_err <= error; winner ack <= 1; winner counter += 1, saturating at all-ones; state -> DONE.
REQ-025 DONE lasts exactly one cycle with the ack high, then the FSM SHALL go to IDLE and clear the ack; requests are ignored in DONE.
REQ-026 Latency SHALL be 2 cycles, from the req sampled in IDLE to the ack; peak throughput SHALL be one access per 3 cycles.
REQ-027 Outside ACCESS, w_mem_we, w_mem_addr and w_mem_din SHALL be 0 (combinational from state).
REQ-028 Requester inputs SHALL be sampled only during ACCESS; a req dropped before the grant SHALL simply not be served.
REQ-029 r_ack0 and r_ack1 SHALL never be high together.

Reset
REQ-030 When w_rst is asserted, the block SHALL immediately return to IDLE and clear r_ack0, r_ack1, r_err, r_rdata, r_cnt0 and r_cnt1; r_last SHALL reset to 1, so port 0 wins the first tie.
REQ-031 Reset during ACCESS SHALL drop w_mem_we combinationally, with no ack and no counter increment.

Verification
REQ-032 Port-0 write addr 0x10, data 0xDEADBEEF, then port-0 read 0x10 -> the second ack carries r_rdata = 0xDEADBEEF, r_err = 0, and r_cnt0 = 2.
REQ-033 Both ports request reads continuously from reset -> the ack order is 0,1,0,1 and each ack is 3 cycles after the previous one.
REQ-034 Port-1 write to addr 0x2002 (misaligned) and to 0x4000 (out of range) -> r_err = 1 and r_rdata = 0 with each ack, and the memory is unchanged.
REQ-035 Assert w_rst during the ACCESS of a port-0 write of 0x55 to addr 0x20 -> no write, no ack, r_cnt0 = 0, and the FSM is in IDLE.
REQ-036 With CNT_W = 2, issue 5 port-0 accesses -> r_cnt0 = 3, saturated.

Source files
------------

// File: rtl/m_memarb.sv
// ---------------------------------------------------------------------------
// m_memarb -- two-port round-robin arbiter in front of a single-port
// 2048x32 memory with combinational read data.
//
// Each access runs IDLE -> ACCESS -> DONE. The winning port's request is
// latched in IDLE. The memory is driven for the single ACCESS cycle. The
// result is registered at the end of ACCESS and shown for the one DONE
// cycle, while the winner's ack is high.
//
// Ports
//   w_clk, w_rst                 clock, asynchronous active-high reset
//   w_req0/1, w_we0/1            request and write enable per port
//   w_addr0/1, w_wdata0/1        byte address and write data per port
//   r_ack0/1                     one-cycle completion pulse per port
//   r_err, r_rdata               access status and read data (valid with ack)
//   w_mem_addr/we/din            memory word address, write enable, data in
//   w_mem_dout                   memory combinational read data
//   r_cnt0/1                     saturating completed-access counters
//   r_busy                       high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module m_memarb #(
    parameter int CNT_W = 16
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_req0,
    input  logic             w_we0,
    input  logic [31:0]      w_addr0,
    input  logic [31:0]      w_wdata0,
    input  logic             w_req1,
    input  logic             w_we1,
    input  logic [31:0]      w_addr1,
    input  logic [31:0]      w_wdata1,
    output logic             r_ack0,
    output logic             r_ack1,
    output logic             r_err,
    output logic [31:0]      r_rdata,
    output logic [10:0]      w_mem_addr,
    output logic             w_mem_we,
    output logic [31:0]      w_mem_din,
    input  logic [31:0]      w_mem_dout,
    output logic [CNT_W-1:0] r_cnt0,
    output logic [CNT_W-1:0] r_cnt1,
    output logic             r_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      nxt_state;

    logic        r_win;   // port being served (0 or 1)
    logic        r_last;  // port granted most recently
    logic        any_req;
    logic        nxt_win;

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        acc_err;

    // Round-robin: on a tie the port that did not win last time is served.
    // A lone request wins regardless of history.
    assign any_req = w_req0 | w_req1;
    assign nxt_win = (w_req0 & w_req1) ? ~r_last : w_req1;

    // The winner's address, data and write enable are used live during ACCESS.
    assign sel_we    = r_win ? w_we1    : w_we0;
    assign sel_addr  = r_win ? w_addr1  : w_addr0;
    assign sel_wdata = r_win ? w_wdata1 : w_wdata0;

    // The byte address must be word aligned and fall inside the 8 KiB array.
    assign acc_err = (sel_addr[1:0] != 2'b00) || (sel_addr[31:13] != 19'd0);

    assign r_busy = (r_state != IDLE);

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= nxt_state;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        nxt_state  = r_state;
        w_mem_we   = 1'b0;
        w_mem_addr = 11'd0;
        w_mem_din  = 32'd0;
        case (r_state)
            IDLE: begin
                if (any_req) begin
                    nxt_state = ACCESS;
                end
            end
            ACCESS: begin
                nxt_state  = DONE;
                w_mem_addr = sel_addr[12:2];
                w_mem_din  = sel_wdata;
                // Gating with reset drops the write strobe as soon as reset
                // rises, without waiting for the state register to clear.
                w_mem_we   = sel_we & ~acc_err & ~w_rst;
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_win   <= 1'b0;
            r_last  <= 1'b1;   // port 0 wins the first tie after reset
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (any_req) begin
                        r_win  <= nxt_win;
                        r_last <= nxt_win;
                    end
                end
                ACCESS: begin
                    r_rdata <= (!sel_we && !acc_err) ? w_mem_dout : 32'd0;
                    r_err   <= acc_err;
                    if (r_win) begin
                        r_ack1 <= 1'b1;
                        if (r_cnt1 != '1) begin
                            r_cnt1 <= r_cnt1 + CNT_W'(1);
                        end
                    end else begin
                        r_ack0 <= 1'b1;
                        if (r_cnt0 != '1) begin
                            r_cnt0 <= r_cnt0 + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                end
                default: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_memarb.sv
// ---------------------------------------------------------------------------
// tb_m_memarb -- directed self-checking bench for m_memarb.
//
// A 2048x32 memory model (write on posedge, combinational read) sits behind
// the main DUT. A second instance with CNT_W = 2 receives the same stimulus,
// so its counter saturation can be compared against the 16-bit counter.
// ---------------------------------------------------------------------------
module tb_m_memarb;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;

    logic        ack0, ack1, err, busy;
    logic [31:0] rdata;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_din, mem_dout;
    logic [15:0] cnt0, cnt1;

    logic        s_ack0, s_ack1, s_err, s_busy;
    logic [31:0] s_rdata;
    logic [10:0] s_mem_addr;
    logic        s_mem_we;
    logic [31:0] s_mem_din, s_mem_dout;
    logic [1:0]  s_cnt0, s_cnt1;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] mem [0:2047];

    m_memarb #(.CNT_W(16)) dut (
        .w_clk(clk), .w_rst(rst),
        .w_req0(req0), .w_we0(we0), .w_addr0(addr0), .w_wdata0(wdata0),
        .w_req1(req1), .w_we1(we1), .w_addr1(addr1), .w_wdata1(wdata1),
        .r_ack0(ack0), .r_ack1(ack1), .r_err(err), .r_rdata(rdata),
        .w_mem_addr(mem_addr), .w_mem_we(mem_we), .w_mem_din(mem_din),
        .w_mem_dout(mem_dout), .r_cnt0(cnt0), .r_cnt1(cnt1), .r_busy(busy)
    );

    m_memarb #(.CNT_W(2)) dut_sat (
        .w_clk(clk), .w_rst(rst),
        .w_req0(req0), .w_we0(we0), .w_addr0(addr0), .w_wdata0(wdata0),
        .w_req1(req1), .w_we1(we1), .w_addr1(addr1), .w_wdata1(wdata1),
        .r_ack0(s_ack0), .r_ack1(s_ack1), .r_err(s_err), .r_rdata(s_rdata),
        .w_mem_addr(s_mem_addr), .w_mem_we(s_mem_we), .w_mem_din(s_mem_din),
        .w_mem_dout(s_mem_dout), .r_cnt0(s_cnt0), .r_cnt1(s_cnt1), .r_busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NOTE: the memory array has no reset; it is zero-filled once at start
    // and then only changes through the write port, like a real SRAM.
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    end

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
    end

    assign mem_dout   = mem[mem_addr];
    assign s_mem_dout = mem[s_mem_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
    endtask

    // Leaves the bench 1 ns after a rising edge, with the FSM in IDLE.
    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One complete request/ack handshake. The call starts and ends 1 ns
    // after a rising edge with the FSM in IDLE.
    task automatic do_access(input int port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata,
                             output logic [31:0] rd, output logic er);
        int lat;
        bit seen;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            if ((port == 0) ? ack0 : ack1) seen = 1'b1;
        end
        check("ack_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'd2);
        check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        check("mem_we_in_done", 32'(mem_we), 32'd0);
        rd = rdata;
        er = err;
        idle_inputs();
        @(posedge clk);
        #1;
        check("ack_cleared", 32'(ack0 | ack1), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          ack_port [4];
        int          ack_cyc  [4];
        logic [31:0] ack_data [4];
        int          n_ack;
        int          cyc;

        // ---------------- reset state ----------------
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_cnt0", 32'(cnt0), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        rst = 1'b0;

        // ---------------- write then read back on port 0 ----------------
        do_access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er);
        check("wr_err", 32'(er), 32'd0);
        check("wr_cnt0", 32'(cnt0), 32'd1);
        check("wr_mem", mem[4], 32'hDEAD_BEEF);
        do_access(0, 1'b0, 32'h0000_0010, 32'd0, rd, er);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_err", 32'(er), 32'd0);
        check("rd_cnt0", 32'(cnt0), 32'd2);
        check("rd_cnt1", 32'(cnt1), 32'd0);

        // ---------------- continuous contention from reset ----------------
        rst = 1'b1;
        idle_inputs();
        req0 = 1'b1; addr0 = 32'h0000_0010;
        req1 = 1'b1; addr1 = 32'h0000_0014;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_ack = 0;
        cyc   = 0;
        while (n_ack < 4 && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            check("rr_exclusive", 32'(ack0 & ack1), 32'd0);
            if (ack0 | ack1) begin
                ack_port[n_ack] = ack1 ? 1 : 0;
                ack_cyc[n_ack]  = cyc;
                ack_data[n_ack] = rdata;
                n_ack++;
            end
        end
        check("rr_count", 32'(n_ack), 32'd4);
        check("rr_first_cycle", 32'(ack_cyc[0]), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("rr_order", 32'(ack_port[i]), 32'(i % 2));
            check("rr_data", ack_data[i], (i % 2 == 0) ? 32'hDEAD_BEEF : 32'd0);
            if (i > 0) check("rr_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end

        // ---------------- error accesses ----------------
        apply_reset();
        do_access(1, 1'b1, 32'h0000_2002, 32'h1234_5678, rd, er);
        check("misalign_err", 32'(er), 32'd1);
        check("misalign_rdata", rd, 32'd0);
        do_access(1, 1'b1, 32'h0000_4000, 32'hCAFE_F00D, rd, er);
        check("range_err", 32'(er), 32'd1);
        check("range_rdata", rd, 32'd0);
        check("err_mem0", mem[0], 32'd0);
        check("err_mem4", mem[4], 32'hDEAD_BEEF);
        check("err_cnt1", 32'(cnt1), 32'd2);
        // A misaligned read of a populated word must still return zero.
        do_access(0, 1'b0, 32'h0000_0011, 32'd0, rd, er);
        check("misalign_rd_err", 32'(er), 32'd1);
        check("misalign_rd_data", rd, 32'd0);

        // ---------------- reset in the middle of ACCESS ----------------
        apply_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0020; wdata0 = 32'h0000_0055;
        @(posedge clk);
        #1;
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_mem_we", 32'(mem_we), 32'd1);
        check("acc_mem_addr", 32'(mem_addr), 32'd8);
        #2;
        rst = 1'b1;
        #1;
        check("rst_acc_mem_we", 32'(mem_we), 32'd0);
        check("rst_acc_busy", 32'(busy), 32'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_acc_mem", mem[8], 32'd0);
        check("rst_acc_ack0", 32'(ack0), 32'd0);
        check("rst_acc_cnt0", 32'(cnt0), 32'd0);
        check("rst_acc_busy2", 32'(busy), 32'd0);

        // ---------------- counter saturation ----------------
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_access(0, 1'b0, 32'h0000_0010, 32'd0, rd, er);
            check("cnt16", 32'(cnt0), 32'(i + 1));
            check("cnt2", 32'(s_cnt0), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
